// File: rtl/bambu_slave_mem_master.sv
// Host-side initiator for the accelerator slave memory port: turns a valid/ready
// command stream into single accesses on channel CH and returns a response stream.
module bambu_slave_mem_master #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SIZE_W   = 4,
    parameter int unsigned CH       = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_we,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    input  logic [SIZE_W-1:0]            cmd_size,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [CHANNELS-1:0]          S_oe_ram,
    output logic [CHANNELS-1:0]          S_we_ram,
    output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
    output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
    output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
    input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [CHANNELS-1:0]          Sout_DataRdy
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e                       state_q, state_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]            rsp_rdata_q, rsp_rdata_d;
    logic                         rsp_err_q, rsp_err_d;
    logic                         we_q, we_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic [SIZE_W-1:0]            size_q, size_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CHANNELS-1:0]          s_oe_q, s_oe_d;
    logic [CHANNELS-1:0]          s_we_q, s_we_d;
    logic [CHANNELS*ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [CHANNELS*DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [CHANNELS*SIZE_W-1:0]   s_size_q, s_size_d;

    logic                         accept;
    logic                         rdy_ch;
    logic                         timeout_hit;
    logic [DATA_W-1:0]            rdata_ch;
    logic                         unused_in;

    assign accept      = cmd_valid && cmd_ready_q;
    assign rdy_ch      = Sout_DataRdy[CH];
    assign rdata_ch    = Sout_Rdata_ram[CH*DATA_W +: DATA_W];
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    // Other channels' slave outputs are deliberately ignored.
    assign unused_in   = ^{Sout_Rdata_ram, Sout_DataRdy};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (rdy_ch || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values; DataRdy wins over timeout.
    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        s_oe_d      = '0;
        s_we_d      = '0;
        s_addr_d    = '0;
        s_wdata_d   = '0;
        s_size_d    = '0;

        if (state_q == IDLE && accept) begin
            we_d    = cmd_we;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            size_d  = cmd_size;
            cnt_d   = '0;
        end

        if (state_q == ISSUE) begin
            if (rdy_ch) begin
                rsp_rdata_d = we_q ? '0 : rdata_ch;
                rsp_err_d   = 1'b0;
                cnt_d       = '0;
            end else if (timeout_hit) begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_q == RESP && rsp_ready) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
        end

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);

        if (state_d == ISSUE) begin
            s_oe_d[CH]                     = ~we_d;
            s_we_d[CH]                     = we_d;
            s_addr_d[CH*ADDR_W +: ADDR_W]  = addr_d;
            s_wdata_d[CH*DATA_W +: DATA_W] = we_d ? wdata_d : '0;
            s_size_d[CH*SIZE_W +: SIZE_W]  = size_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            cnt_q       <= '0;
            s_oe_q      <= '0;
            s_we_q      <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_size_q    <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            s_oe_q      <= s_oe_d;
            s_we_q      <= s_we_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_size_q    <= s_size_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign S_oe_ram        = s_oe_q;
    assign S_we_ram        = s_we_q;
    assign S_addr_ram      = s_addr_q;
    assign S_Wdata_ram     = s_wdata_q;
    assign S_data_ram_size = s_size_q;

endmodule

// File: tb/tb_bambu_slave_mem_master.sv
// Bench for bambu_slave_mem_master: one master on channel 0 (long timeout) and one
// on channel 1 (TIMEOUT=4) share the slave inputs; a memory model supplies read data.
module tb_bambu_slave_mem_master;
    localparam int unsigned CHN = 2;
    localparam int unsigned AW  = 7;
    localparam int unsigned DW  = 8;
    localparam int unsigned SW  = 4;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic              clock;
    logic              reset;
    logic [1:0]        cmd_valid_v;
    logic              cmd_we;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic [SW-1:0]     cmd_size;
    logic              rsp_ready;
    logic [CHN*DW-1:0] sout_rdata;
    logic [CHN-1:0]    sout_rdy;

    logic              cmd_ready0, cmd_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [DW-1:0]     rsp_rdata0, rsp_rdata1;
    logic [CHN-1:0]    s_oe0, s_oe1, s_we0, s_we1;
    logic [CHN*AW-1:0] s_addr0, s_addr1;
    logic [CHN*DW-1:0] s_wdata0, s_wdata1;
    logic [CHN*SW-1:0] s_size0, s_size1;

    int                sel;
    logic              cur_cmd_ready, cur_rsp_valid, cur_rsp_err;
    logic [DW-1:0]     cur_rsp_rdata;
    logic [CHN-1:0]    cur_s_oe, cur_s_we;
    logic [CHN*AW-1:0] cur_s_addr;
    logic [CHN*DW-1:0] cur_s_wdata;
    logic [CHN*SW-1:0] cur_s_size;

    int                tests;
    int                fails;
    rsp_t              sb_q[$];
    logic [DW-1:0]     mem [128];

    bambu_slave_mem_master #(.CHANNELS(CHN), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
                             .CH(0), .TIMEOUT(16)) dut0 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready0), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .S_oe_ram(s_oe0), .S_we_ram(s_we0), .S_addr_ram(s_addr0), .S_Wdata_ram(s_wdata0),
        .S_data_ram_size(s_size0), .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy)
    );

    bambu_slave_mem_master #(.CHANNELS(CHN), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
                             .CH(1), .TIMEOUT(4)) dut1 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready1), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .S_oe_ram(s_oe1), .S_we_ram(s_we1), .S_addr_ram(s_addr1), .S_Wdata_ram(s_wdata1),
        .S_data_ram_size(s_size1), .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        cur_cmd_ready = (sel == 1) ? cmd_ready1 : cmd_ready0;
        cur_rsp_valid = (sel == 1) ? rsp_valid1 : rsp_valid0;
        cur_rsp_err   = (sel == 1) ? rsp_err1   : rsp_err0;
        cur_rsp_rdata = (sel == 1) ? rsp_rdata1 : rsp_rdata0;
        cur_s_oe      = (sel == 1) ? s_oe1      : s_oe0;
        cur_s_we      = (sel == 1) ? s_we1      : s_we0;
        cur_s_addr    = (sel == 1) ? s_addr1    : s_addr0;
        cur_s_wdata   = (sel == 1) ? s_wdata1   : s_wdata0;
        cur_s_size    = (sel == 1) ? s_size1    : s_size0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete access: command handshake, issue_cycles of ISSUE (DataRdy in the
    // last one when rdy), then bp cycles of response back-pressure before consuming it.
    task automatic do_access(input int ch, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] size,
                             input int issue_cycles, input logic rdy, input int bp);
        rsp_t        exp;
        int          n;
        logic [31:0] e_oe, e_we, e_addr, e_wd, e_sz;
        logic [DW-1:0] held;
        sel    = ch;
        e_oe   = 32'(!we) << ch;
        e_we   = 32'(we) << ch;
        e_addr = 32'(addr) << (ch * AW);
        e_wd   = we ? (32'(wdata) << (ch * DW)) : 32'd0;
        e_sz   = 32'(size) << (ch * SW);
        cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        cmd_valid_v = 2'(1) << ch;
        #1;
        n = 0;
        while (cur_cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("cmd_ready_wait", 32'(n < 20), 32'd1);
        @(negedge clock);
        cmd_valid_v = '0;
        exp.rdata = (rdy && !we) ? mem[addr] : 8'h00;
        exp.err   = !rdy;
        sb_q.push_back(exp);
        if (rdy && we) mem[addr] = wdata;
        chk("cmd_ready_drop", 32'(cur_cmd_ready), 32'd0);
        for (int i = 1; i <= issue_cycles; i++) begin
            chk("s_oe", 32'(cur_s_oe), e_oe);
            chk("s_we", 32'(cur_s_we), e_we);
            chk("s_addr", 32'(cur_s_addr), e_addr);
            chk("s_wdata", 32'(cur_s_wdata), e_wd);
            chk("s_size", 32'(cur_s_size), e_sz);
            chk("rsp_valid_issue", 32'(cur_rsp_valid), 32'd0);
            sout_rdy   = '0;
            sout_rdata = '0;
            sout_rdata[(1 - ch) * DW +: DW] = 8'h5A;
            if (i == 1) sout_rdy[1 - ch] = 1'b1;
            if (i == issue_cycles && rdy) begin
                sout_rdy[ch] = 1'b1;
                sout_rdata[ch * DW +: DW] = exp.rdata;
            end
            @(negedge clock);
        end
        sout_rdy = '0;
        chk("s_oe_done", 32'(cur_s_oe), 32'd0);
        chk("s_we_done", 32'(cur_s_we), 32'd0);
        chk("rsp_valid", 32'(cur_rsp_valid), 32'd1);
        exp = sb_q.pop_front();
        chk("rsp_rdata", 32'(cur_rsp_rdata), 32'(exp.rdata));
        chk("rsp_err", 32'(cur_rsp_err), 32'(exp.err));
        held = cur_rsp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clock);
            chk("bp_rsp_valid", 32'(cur_rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(cur_rsp_rdata), 32'(held));
            chk("bp_cmd_ready", 32'(cur_cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", 32'(cur_rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cur_cmd_ready), 32'd1);
    endtask

    initial begin
        tests = 0; fails = 0; sel = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3 + 1);
        reset = 1'b0; cmd_valid_v = '0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_size = '0; rsp_ready = 1'b0; sout_rdata = '0; sout_rdy = '0;
        #1;
        chk("rst_cmd_ready", 32'({cmd_ready1, cmd_ready0}), 32'd0);
        chk("rst_rsp_valid", 32'({rsp_valid1, rsp_valid0}), 32'd0);
        chk("rst_rsp_out", 32'({rsp_rdata0, rsp_err0, rsp_rdata1, rsp_err1}), 32'd0);
        chk("rst_s_ctl", 32'({s_oe0, s_we0, s_oe1, s_we1}), 32'd0);
        chk("rst_s_addr", 32'({s_addr0, s_addr1}), 32'd0);
        chk("rst_s_data", 32'({s_wdata0, s_wdata1, s_size0, s_size1}), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_access(0, 1'b1, 7'h05, 8'hA5, 4'd8, 1, 1'b1, 0);
        do_access(0, 1'b0, 7'h05, 8'h00, 4'd8, 1, 1'b1, 0);
        do_access(0, 1'b0, 7'h05, 8'h00, 4'd8, 10, 1'b1, 0);
        do_access(1, 1'b0, 7'h10, 8'h00, 4'd8, 4, 1'b0, 0);
        do_access(1, 1'b1, 7'h7F, 8'h3C, 4'd8, 2, 1'b1, 0);
        do_access(1, 1'b0, 7'h7F, 8'h00, 4'd8, 3, 1'b1, 0);
        do_access(0, 1'b0, 7'h21, 8'h00, 4'd4, 3, 1'b1, 5);
        do_access(0, 1'b1, 7'h33, 8'hC3, 4'd0, 2, 1'b1, 1);

        // Asynchronous reset while an access is in ISSUE.
        sel = 0; cmd_we = 1'b0; cmd_addr = 7'h22; cmd_size = 4'd8; cmd_valid_v = 2'b01;
        @(negedge clock);
        @(negedge clock);
        cmd_valid_v = '0;
        chk("rst_mid_pre_oe", 32'(s_oe0), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(s_oe0), 32'd0);
        chk("rst_mid_addr", 32'(s_addr0), 32'd0);
        chk("rst_mid_size", 32'(s_size0), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready0), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_no_rsp", 32'(rsp_valid0), 32'd0);
        end
        do_access(0, 1'b0, 7'h33, 8'h00, 4'd8, 2, 1'b1, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bambu_slave_mem_master.md
Name: bambu_slave_mem_master

Overview:
- Host-side initiator for the accelerator's slave memory port (S_oe_ram / S_we_ram / S_addr_ram / S_Wdata_ram / S_data_ram_size in; Sout_Rdata_ram / Sout_DataRdy out).
- Converts a valid/ready command stream (read or write, address, data, size) into slave-port accesses on one selected channel.
- Returns read data and status on a valid/ready response stream, with a timeout on missing DataRdy.
- Used by simulation and integration benches to preload inputs and read back results, replacing the all-zero tie-off of the slave port.

Parameters:
- CHANNELS, 2, number of slave-port channels packed in each S_* bus.
- ADDR_W, 7, address bits per channel.
- DATA_W, 8, data bits per channel.
- SIZE_W, 4, data_ram_size bits per channel (access size in bits).
- CH, 0, channel index this master drives; must be < CHANNELS.
- TIMEOUT, 255, max cycles waiting for DataRdy before error; must be >= 1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_size  in  SIZE_W  access size in bits, forwarded unchanged.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts).
- rsp_err  out  1  1 = timeout.
- S_oe_ram  out  CHANNELS  read enable per channel.
- S_we_ram  out  CHANNELS  write enable per channel.
- S_addr_ram  out  CHANNELS*ADDR_W  packed address; channel k at [k*ADDR_W +: ADDR_W].
- S_Wdata_ram  out  CHANNELS*DATA_W  packed write data.
- S_data_ram_size  out  CHANNELS*SIZE_W  packed size.
- Sout_Rdata_ram  in  CHANNELS*DATA_W  packed read data.
- Sout_DataRdy  in  CHANNELS  access-complete per channel.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all S_* outputs 0; cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; timeout counter 0.
- Channels other than CH: all S_* slices held at 0 permanently.
- IDLE:
  - cmd_ready=1.
  - On accept: latch we/addr/wdata/size into registers; next state ISSUE.
  - cmd_ready is registered; it drops the cycle after accept.
- ISSUE:
  - S_oe_ram[CH]=~we and S_we_ram[CH]=we; addr, Wdata and size slices driven from the latched registers.
  - Wdata slice is 0 for reads.
  - Request held stable every cycle until completion.
  - Counter increments each cycle in ISSUE.
  - If Sout_DataRdy[CH]=1 on a rising edge: capture rdata (reads) or 0 (writes), err=0, deassert oe/we, clear counter, go RESP.
  - Else if counter reaches TIMEOUT: deassert oe/we, rdata=0, err=1, go RESP.
  - DataRdy has priority over timeout on the same edge.
  - Minimum latency from accept to rsp_valid: 2 cycles (DataRdy high in the first ISSUE cycle).
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable until handshake.
  - On rsp_ready: rsp_valid=0, go IDLE. No command is accepted in the same cycle (one outstanding access, no pipelining).
- Sout_DataRdy[CH] outside ISSUE and DataRdy on other channels: ignored.
- Commands are never dropped; back-pressure only via cmd_ready.
- Reset asserted mid-access: all outputs forced to reset values immediately and the pending access is abandoned, with no response.
- Writes with cmd_size=0 are still issued unchanged; the slave defines their meaning.

Test Plan:
- Write then read: write addr=0x05 data=0xA5 size=8, slave returns DataRdy after 1 cycle -> S_we_ram=2'b01 for 1 cycle, addr slice=0x05; rsp_err=0. Then read 0x05 -> S_oe_ram=2'b01, rsp_rdata=0xA5, accept-to-rsp_valid 2 cycles.
- Delayed slave: DataRdy after 10 cycles -> oe, addr and size stable all 10 cycles; exactly one response with correct data.
- Timeout, TIMEOUT=4: slave never responds -> oe drops after 4 ISSUE cycles; rsp_err=1, rsp_rdata=0; next command proceeds normally.
- Response back-pressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; one cycle after rsp_ready=1, cmd_ready=1.
- Channel isolation, CH=1: write 0x7F/0x3C -> S_addr_ram[13:7]=0x7F, S_addr_ram[6:0]=0, S_we_ram=2'b10; DataRdy[0] pulses are ignored.
- Async reset during ISSUE -> all S_* outputs 0 without a clock edge; no rsp_valid after release; next command completes normally.
